// File: rtl/local_maxima_stream.sv
// Streaming 3x3 local-maximum detector for COLS x ROWS raster images.
// Pixels enter one per input handshake. One flag per pixel leaves in raster
// order through a single-entry output register. The block flushes itself
// with zero samples at end of frame and pulses finish after the last flag.
module local_maxima_stream #(
  parameter int PIX_W  = 8,
  parameter int COLS   = 6,
  parameter int ROWS   = 6,
  parameter bit STRICT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_max,
  output logic             out_last,
  output logic             finish
);

  localparam int NPIX  = ROWS * COLS;
  localparam int CNT_W = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  // The 2*COLS+3 window is the incoming sample plus this many stored pixels.
  localparam int WIN_D = 2 * COLS + 2;

  typedef enum logic [1:0] {FILL, RUN, FLUSH, DONE} state_e;

  state_e                       state_q, state_d;
  logic [WIN_D-1:0][PIX_W-1:0]  win_q, win_d;
  logic [CNT_W-1:0]             in_cnt_q, in_cnt_d;
  logic [ROW_W-1:0]             row_q, row_d;
  logic [COL_W-1:0]             col_q, col_d;
  logic                         out_valid_q, out_valid_d;
  logic                         out_max_q, out_max_d;
  logic                         out_last_q, out_last_d;
  logic                         finish_q, finish_d;
  logic                         live_q;

  logic             slot_free;
  logic             step;
  logic             produce;
  logic [PIX_W-1:0] sample;
  logic             is_max;

  // Centre and its eight neighbours after this step's shift; masked to zero
  // outside the image using the centre counters, never the buffer contents.
  logic             top, bot, lft, rgt;
  logic [PIX_W-1:0] ctr;
  logic [PIX_W-1:0] n_tl, n_t, n_tr, n_l, n_r, n_bl, n_b, n_br;

  function automatic logic beats(input logic [PIX_W-1:0] c,
                                 input logic [PIX_W-1:0] n);
    return STRICT ? (c > n) : (c >= n);
  endfunction

  assign slot_free = !out_valid_q || out_ready;

  // Neighbour selection, border masking and the 8-way compare.
  always_comb begin
    top  = (row_q == '0);
    bot  = (row_q == ROW_W'(ROWS - 1));
    lft  = (col_q == '0);
    rgt  = (col_q == COL_W'(COLS - 1));
    ctr  = win_q[COLS];
    n_tl = (top || lft) ? '0 : win_q[2*COLS+1];
    n_t  = top          ? '0 : win_q[2*COLS];
    n_tr = (top || rgt) ? '0 : win_q[2*COLS-1];
    n_l  = lft          ? '0 : win_q[COLS+1];
    n_r  = rgt          ? '0 : win_q[COLS-1];
    n_bl = (bot || lft) ? '0 : win_q[1];
    n_b  = bot          ? '0 : win_q[0];
    n_br = (bot || rgt) ? '0 : sample;
    is_max = beats(ctr, n_tl) && beats(ctr, n_t)  && beats(ctr, n_tr) &&
             beats(ctr, n_l)  && beats(ctr, n_r)  &&
             beats(ctr, n_bl) && beats(ctr, n_b)  && beats(ctr, n_br);
  end

  // Frame FSM: decides handshake, step, producing step and next state.
  // NOTE: every output of a combinational block is assigned a default first,
  // so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    step     = 1'b0;
    produce  = 1'b0;
    sample   = in_data;
    unique case (state_q)
      FILL: begin
        in_ready = en && live_q;
        if (in_ready && in_valid) begin
          step = 1'b1;
          if (in_cnt_q == CNT_W'(COLS)) state_d = RUN;
        end
      end
      RUN: begin
        in_ready = en && live_q && slot_free;
        if (in_ready && in_valid) begin
          step    = 1'b1;
          produce = 1'b1;
          if (in_cnt_q == CNT_W'(NPIX - 1)) state_d = FLUSH;
        end
      end
      FLUSH: begin
        sample = '0;
        if (en && slot_free) begin
          step    = 1'b1;
          produce = 1'b1;
          if (in_cnt_q == CNT_W'(COLS)) state_d = DONE;
        end
      end
      DONE: begin
        if (finish_q) state_d = FILL;
      end
      default: state_d = FILL;
    endcase
  end

  // Next-state for window, counters and the output register.
  always_comb begin
    win_d       = win_q;
    in_cnt_d    = in_cnt_q;
    row_d       = row_q;
    col_d       = col_q;
    out_valid_d = out_valid_q;
    out_max_d   = out_max_q;
    out_last_d  = out_last_q;
    finish_d    = (state_q == DONE) && en && out_valid_q && out_ready && out_last_q;

    if (step) begin
      win_d = {win_q[WIN_D-2:0], sample};
      // In FLUSH the pixel counter is reused to count the COLS+1 flush steps.
      if (state_q == FLUSH) begin
        in_cnt_d = (in_cnt_q == CNT_W'(COLS)) ? '0 : in_cnt_q + CNT_W'(1);
      end else begin
        in_cnt_d = (in_cnt_q == CNT_W'(NPIX - 1)) ? '0 : in_cnt_q + CNT_W'(1);
      end
    end

    if (produce) begin
      out_valid_d = 1'b1;
      out_max_d   = is_max;
      out_last_d  = bot && rgt;
      if (rgt) begin
        col_d = '0;
        row_d = bot ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end else if (en && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers with asynchronous active-low reset.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  // NOTE: the window buffer is reset too: a mid-frame reset must leave a
  // clean, deterministic block, and the buffer is small enough to afford it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= FILL;
      win_q       <= '0;
      in_cnt_q    <= '0;
      row_q       <= '0;
      col_q       <= '0;
      out_valid_q <= 1'b0;
      out_max_q   <= 1'b0;
      out_last_q  <= 1'b0;
      finish_q    <= 1'b0;
      live_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      in_cnt_q    <= in_cnt_d;
      row_q       <= row_d;
      col_q       <= col_d;
      out_valid_q <= out_valid_d;
      out_max_q   <= out_max_d;
      out_last_q  <= out_last_d;
      finish_q    <= finish_d;
      // Holds in_ready low while reset is asserted and on the first edge after.
      live_q      <= 1'b1;
    end
  end

  assign out_valid = out_valid_q;
  assign out_max   = out_max_q;
  assign out_last  = out_last_q;
  assign finish    = finish_q;

endmodule

// File: tb/tb_local_maxima_stream.sv
// Directed bench for local_maxima_stream: two 6x6 instances (STRICT=1 and
// STRICT=0) run in lockstep, plus a 12-bit 8x4 instance.
module tb_local_maxima_stream;

  localparam int N6 = 36;
  localparam int N8 = 32;

  logic clk = 1'b0;
  logic rst;
  logic en;

  logic       in_valid_ab, out_ready_ab;
  logic [7:0] in_data_ab;
  logic in_ready_a, out_valid_a, out_max_a, out_last_a, finish_a;
  logic in_ready_b, out_valid_b, out_max_b, out_last_b, finish_b;

  logic        in_valid_c, out_ready_c;
  logic [11:0] in_data_c;
  logic in_ready_c, out_valid_c, out_max_c, out_last_c, finish_c;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  local_maxima_stream #(.PIX_W(8), .COLS(6), .ROWS(6), .STRICT(1'b1)) dut_a (
    .clk(clk), .rst(rst), .en(en),
    .in_valid(in_valid_ab), .in_ready(in_ready_a), .in_data(in_data_ab),
    .out_valid(out_valid_a), .out_ready(out_ready_ab), .out_max(out_max_a),
    .out_last(out_last_a), .finish(finish_a));

  local_maxima_stream #(.PIX_W(8), .COLS(6), .ROWS(6), .STRICT(1'b0)) dut_b (
    .clk(clk), .rst(rst), .en(en),
    .in_valid(in_valid_ab), .in_ready(in_ready_b), .in_data(in_data_ab),
    .out_valid(out_valid_b), .out_ready(out_ready_ab), .out_max(out_max_b),
    .out_last(out_last_b), .finish(finish_b));

  local_maxima_stream #(.PIX_W(12), .COLS(8), .ROWS(4), .STRICT(1'b1)) dut_c (
    .clk(clk), .rst(rst), .en(en),
    .in_valid(in_valid_c), .in_ready(in_ready_c), .in_data(in_data_c),
    .out_valid(out_valid_c), .out_ready(out_ready_c), .out_max(out_max_c),
    .out_last(out_last_c), .finish(finish_c));

  typedef struct {
    logic [7:0]  bg;
    int          hot_idx;
    logic [7:0]  hot_val;
    logic [35:0] exp_a;
    logic [35:0] exp_b;
  } vec_t;

  vec_t vecs [5];

  logic [7:0]  img_ab [N6];
  logic [11:0] img_c  [N8];

  logic [35:0] got_a, got_b;
  int got_n, last_idx, n_last, last_hs_cyc, fin_cyc;
  int first_acc_cyc, acc7_cyc, first_ov_cyc;
  bit stable_ok;

  logic [31:0] got_c;
  int c_n, c_last_idx, c_last_hs, c_fin;

  task automatic check(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic build_ab(input logic [7:0] bg, input int idx, input logic [7:0] val);
    for (int i = 0; i < N6; i++) img_ab[i] = bg;
    img_ab[idx] = val;
  endtask

  // Feeds img_ab to the 6x6 pair; vpct/rpct are in_valid/out_ready percentages.
  task automatic feed_ab(input int vpct, input int rpct);
    int  pi = 0;
    int  oi = 0;
    int  cyc = 0;
    bit  hold = 1'b0;
    logic hold_max = 1'b0;
    logic hold_last = 1'b0;
    got_a = '0; got_b = '0; last_idx = -1; n_last = 0; last_hs_cyc = -1;
    fin_cyc = -1; first_acc_cyc = -1; acc7_cyc = -1; first_ov_cyc = -1;
    stable_ok = 1'b1;
    while (fin_cyc < 0 && cyc < 2000) begin
      @(negedge clk);
      in_valid_ab  = (pi < N6) && ($urandom_range(99) < vpct);
      in_data_ab   = img_ab[(pi < N6) ? pi : 0];
      out_ready_ab = ($urandom_range(99) < rpct);
      #1;
      if (finish_a) fin_cyc = cyc;
      if (out_valid_a && first_ov_cyc < 0) first_ov_cyc = cyc;
      if (hold && !(out_valid_a && out_max_a == hold_max && out_last_a == hold_last))
        stable_ok = 1'b0;
      if (in_valid_ab && in_ready_a) begin
        if (pi == 0) first_acc_cyc = cyc;
        if (pi == 7) acc7_cyc = cyc;
        pi++;
      end
      if (out_valid_a && out_ready_ab) begin
        if (oi < N6) begin
          got_a[oi] = out_max_a;
          got_b[oi] = out_max_b;
        end
        if (out_last_a) begin
          last_idx = oi;
          last_hs_cyc = cyc;
          n_last++;
        end
        oi++;
      end
      hold      = out_valid_a && !out_ready_ab;
      hold_max  = out_max_a;
      hold_last = out_last_a;
      cyc++;
    end
    in_valid_ab = 1'b0;
    got_n = oi;
  endtask

  task automatic check_frame(input string tag, input logic [35:0] ea,
                             input logic [35:0] eb, input bit full_rate);
    check({tag, "_done"}, fin_cyc >= 0, 1);
    check({tag, "_flags_strict"}, got_a, ea);
    check({tag, "_flags_ge"}, got_b, eb);
    check({tag, "_count"}, got_n, N6);
    check({tag, "_last_idx"}, last_idx, N6 - 1);
    check({tag, "_last_once"}, n_last, 1);
    check({tag, "_finish_delay"}, fin_cyc - last_hs_cyc, 1);
    if (full_rate) begin
      check({tag, "_latency"}, first_ov_cyc - acc7_cyc, 1);
      check({tag, "_frame_cycles"}, fin_cyc - first_acc_cyc, N6 + 6 + 2);
    end
  endtask

  task automatic feed_c();
    int pi = 0;
    int oi = 0;
    int cyc = 0;
    got_c = '0; c_last_idx = -1; c_last_hs = -1; c_fin = -1;
    while (c_fin < 0 && cyc < 500) begin
      @(negedge clk);
      in_valid_c  = (pi < N8);
      in_data_c   = img_c[(pi < N8) ? pi : 0];
      out_ready_c = 1'b1;
      #1;
      if (finish_c) c_fin = cyc;
      if (in_valid_c && in_ready_c) pi++;
      if (out_valid_c && out_ready_c) begin
        if (oi < N8) got_c[oi] = out_max_c;
        if (out_last_c) begin
          c_last_idx = oi;
          c_last_hs = cyc;
        end
        oi++;
      end
      cyc++;
    end
    in_valid_c = 1'b0;
    c_n = oi;
  endtask

  initial begin
    int pi;
    int cyc;

    vecs[0] = '{bg: 8'd0,  hot_idx: 0,  hot_val: 8'd0,   exp_a: 36'h0_0000_0000, exp_b: 36'hF_FFFF_FFFF};
    vecs[1] = '{bg: 8'd10, hot_idx: 15, hot_val: 8'd200, exp_a: 36'h0_0000_8000, exp_b: 36'hF_FF8E_B8FF};
    vecs[2] = '{bg: 8'd0,  hot_idx: 0,  hot_val: 8'd5,   exp_a: 36'h0_0000_0001, exp_b: 36'hF_FFFF_FF3D};
    vecs[3] = '{bg: 8'd7,  hot_idx: 35, hot_val: 8'd9,   exp_a: 36'h8_0000_0000, exp_b: 36'hB_CFFF_FFFF};
    vecs[4] = '{bg: 8'd50, hot_idx: 21, hot_val: 8'd49,  exp_a: 36'h0_0000_0000, exp_b: 36'hF_FFDF_FFFF};

    rst = 1'b0; en = 1'b1;
    in_valid_ab = 1'b0; out_ready_ab = 1'b0; in_data_ab = '0;
    in_valid_c = 1'b0; out_ready_c = 1'b0; in_data_c = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {in_ready_a, out_valid_a, out_max_a, out_last_a, finish_a,
           in_ready_b, out_valid_b, out_max_b, out_last_b, finish_b,
           in_ready_c, out_valid_c, out_max_c, out_last_c, finish_c}, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    en = 1'b0; #1;
    check("en_low_ready", in_ready_a, 0);
    en = 1'b1; #1;
    check("en_high_ready", in_ready_a, 1);

    // Back-to-back full-rate frames, no reset in between.
    for (int v = 0; v < 5; v++) begin
      build_ab(vecs[v].bg, vecs[v].hot_idx, vecs[v].hot_val);
      feed_ab(100, 100);
      check_frame($sformatf("vec%0d", v), vecs[v].exp_a, vecs[v].exp_b, 1'b1);
    end

    // Same hot-pixel image under random flow control on both sides.
    build_ab(8'd10, 15, 8'd200);
    feed_ab(50, 50);
    check_frame("rand", vecs[1].exp_a, vecs[1].exp_b, 1'b0);
    check("rand_stable", stable_ok, 1);

    // 12-bit 8x4 instance: hot corners.
    for (int i = 0; i < N8; i++) img_c[i] = 12'd1;
    img_c[0] = 12'd4095;
    feed_c();
    check("c00_done", c_fin >= 0, 1);
    check("c00_flags", got_c, 32'h0000_0001);
    check("c00_count", c_n, N8);
    check("c00_last_idx", c_last_idx, N8 - 1);
    check("c00_finish_delay", c_fin - c_last_hs, 1);
    img_c[0] = 12'd1;
    img_c[31] = 12'd4095;
    feed_c();
    check("c37_done", c_fin >= 0, 1);
    check("c37_flags", got_c, 32'h8000_0000);
    check("c37_count", c_n, N8);

    // Reset asserted mid-RUN just after pixel 20 is accepted.
    build_ab(8'd10, 15, 8'd200);
    pi = 0;
    cyc = 0;
    while (pi < 21 && cyc < 100) begin
      @(negedge clk);
      in_valid_ab  = 1'b1;
      in_data_ab   = img_ab[(pi < N6) ? pi : 0];
      out_ready_ab = 1'b1;
      #1;
      if (in_ready_a) pi++;
      cyc++;
    end
    check("rst_reach_px20", pi, 21);
    @(posedge clk);
    #2;
    check("pre_rst_valid", {out_valid_a, out_valid_b, out_max_b}, 3'b111);
    rst = 1'b0;
    #1;
    check("mid_rst_outputs",
          {in_ready_a, out_valid_a, out_max_a, out_last_a, finish_a,
           in_ready_b, out_valid_b, out_max_b, out_last_b, finish_b}, 0);
    @(negedge clk);
    in_valid_ab = 1'b0;
    rst = 1'b1;
    feed_ab(100, 100);
    check_frame("post_rst", vecs[1].exp_a, vecs[1].exp_b, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/local_maxima_stream.md
# local_maxima_stream

Parametrised streaming 3x3 local-maximum detector for PIX_W-bit raster images of COLS x ROWS pixels. It accepts pixels one per handshake and emits one flag per pixel in raster order. The flag is 1 when the centre pixel beats all 8 neighbours; out-of-image neighbours read as 0. It takes valid/ready flow control on both sides and flushes itself at end of frame. It is the frame-agnostic successor of the fixed 6x6 detector and sits between the pixel source and the maxima map consumer.

## Interface
- PIX_W, 8, pixel width in bits (>= 1)
- COLS, 6, image width in pixels (>= 3)
- ROWS, 6, image height in pixels (>= 2)
- STRICT, 1, 1: centre must be strictly greater than every neighbour; 0: greater-or-equal
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- en  in  1  global enable; when 0 no step occurs, all state holds, in_ready=0
- in_valid  in  1  in_data valid
- in_ready  out  1  block accepts in_data this cycle
- in_data  in  PIX_W  pixel, raster order, row 0 col 0 first
- out_valid  out  1  out_max valid
- out_ready  in  1  consumer accepts out_max this cycle
- out_max  out  1  local-maximum flag for current output pixel
- out_last  out  1  qualifies the final pixel (ROWS*COLS-1) of the frame
- finish  out  1  one-cycle pulse, cycle after out_last handshake

## Operation
- Window store: shift register of 2*COLS+3 pixels; one shift per step. The incoming sample is the bottom-right neighbour; the centre sits COLS+1 positions back.
- Neighbour masking comes from centre row/col counters, never buffer contents. Row 0 zeroes the top three, row ROWS-1 the bottom three, col 0 the left three, col COLS-1 the right three. Masked value = 0.
- Compare: out_max = AND over 8 neighbours of (centre > n) when STRICT=1, (centre >= n) when STRICT=0. Compare is unsigned.
- slot_free = !out_valid || out_ready.
- FSM states FILL, RUN, FLUSH, DONE; reset state FILL.
- FILL: in_ready=en. A step happens on in_valid&&in_ready and shifts the pixel in, with no output. After COLS+1 accepted pixels go to RUN.
- RUN: in_ready=en&&slot_free. A step shifts in_data and produces one output. After pixel ROWS*COLS-1 is accepted go to FLUSH.
- FLUSH: in_ready=0. A step happens when en&&slot_free; it shifts in zero and produces one output. After COLS+1 steps go to DONE.
- DONE: waits for the out_last handshake, pulses finish, then returns to FILL for the next frame. in_ready=0.
- Counters: in_cnt, 0..ROWS*COLS-1. Centre row/col counters advance on each producing step; col wraps at COLS-1 to 0 and increments row; both wrap to 0 after the last pixel. Counter width is $clog2 of its range, minimum 1.
- Output register: loaded on a producing step (out_valid<=1, out_max, out_last). Otherwise it clears out_valid when out_ready. Loading and draining in the same cycle is legal.

## Timing
- Reset values: in_ready=0, out_valid=0, out_max=0, out_last=0, finish=0, all counters 0, window 0, state FILL. Reset is asynchronous and may occur mid-frame; the frame is discarded and the next pixel after release is row 0 col 0.
- Latency: the flag for pixel k appears one cycle after the step consuming pixel k+COLS+1, or after flush step k+COLS+1-ROWS*COLS.
- Throughput: with en=1, in_valid=1 and out_ready=1 throughout, one pixel in and one flag out per cycle. The frame occupies ROWS*COLS+COLS+2 cycles from first accept to finish, plus one DONE cycle.
- in_ready is combinational from state, en, out_valid and out_ready; no combinational path from in_valid.
- en=0 overrides everything: no step, no output drain, finish not generated that cycle.
- Back-to-back frames: the first pixel of the next frame is accepted no earlier than the cycle after finish.

## Test plan
- 6x6 all pixels 0, STRICT=1, full-rate -> 36 flags all 0, out_last on the 36th, finish one cycle later. Same with STRICT=0 -> all 36 flags 1.
- 6x6 background 10 with pixel 200 at row 2 col 3, STRICT=1 -> only the flag at index 15 is 1. Border pixels equal 10, so they stay 0.
- Same image with in_valid a random 50% and out_ready a random 50% -> identical flag sequence, no loss or duplication, and out_max/out_last stable while out_valid && !out_ready.
- Latency check, full-rate 6x6: first out_valid rises one cycle after pixel index 7 is accepted. Two consecutive frames must give independent correct results.
- PIX_W=12, COLS=8, ROWS=4, corner pixel (0,0)=4095 with all others 1 -> index 0 flag 1. Pixel (3,7)=4095 -> index 31 flag 1. All others 0.
- Assert rst low mid-RUN at pixel 20 -> all outputs 0 immediately. A new full frame after release must produce the correct 36 flags.
